// File: rtl/tab_collector.sv
// tab_collector
//
// Consumer that sits after the x3 table generator. It watches the generator's
// (index, result) stream and stores each new table entry in a small buffer.
// Every stored entry is checked for a correct product and for the index
// following the previous one. A running sum of results is kept. Once the
// final entry has been stored, the buffer is drained through a valid/ready
// port, and then done is raised.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active low
//   index      in   [3:0] table index from the generator
//   result     in   [7:0] table result from the generator
//   out_ready  in   downstream accepts the current beat
//   out_valid  out  out_index/out_result hold a valid beat
//   out_index  out  [3:0] index of the drained entry
//   out_result out  [7:0] result of the drained entry
//   sum        out  [11:0] running sum of captured results
//   err_count  out  [3:0] erroneous entries seen, saturating at 15
//   error      out  sticky flag: any entry error or buffer overflow
//   done       out  drain complete, held until reset

module tab_collector #(
    parameter int MULT       = 3,
    parameter int LAST_INDEX = 10,
    parameter int DEPTH      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  index,
    input  logic [7:0]  result,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  out_index,
    output logic [7:0]  out_result,
    output logic [11:0] sum,
    output logic [3:0]  err_count,
    output logic        error,
    output logic        done
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        COLLECT,
        DRAIN,
        FINISHED
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [11:0]   entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          have_first;
    logic [3:0]    last_idx;

    logic          capture;
    logic          entry_bad;
    logic          hit_last;
    logic          hit_full;
    logic          transfer;
    logic          last_beat;
    logic [11:0]   head;
    logic [9:0]    expected_result;

    // The product is formed in 10 bits so that an 8-bit result can never
    // alias a larger product.
    assign expected_result = 10'(MULT) * {6'd0, index};

    assign done = (state == FINISHED);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode.
    // A capture happens only when the index changes (or on the very first
    // sample), so the generator's repeated index 0 after reset is absorbed.
    // The index sequence check wraps in 4 bits, like the index itself.
    always_comb begin
        capture    = 1'b0;
        entry_bad  = 1'b0;
        hit_last   = 1'b0;
        hit_full   = 1'b0;
        transfer   = 1'b0;
        last_beat  = 1'b0;
        out_valid  = 1'b0;
        out_index  = 4'd0;
        out_result = 8'd0;
        state_next = state;
        head       = entries[rd_ptr[AW-1:0]];

        case (state)
            COLLECT: begin
                capture = !have_first || (index != last_idx);
                if (capture) begin
                    entry_bad = ({2'b00, result} != expected_result) ||
                                (have_first && (index != last_idx + 4'd1));
                    hit_last  = (index == 4'(LAST_INDEX));
                    hit_full  = (wr_ptr == PW'(DEPTH - 1));
                    if (hit_last || hit_full) begin
                        state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                out_valid = (rd_ptr < wr_ptr);
                if (out_valid) begin
                    out_index  = head[11:8];
                    out_result = head[7:0];
                end
                transfer  = out_valid && out_ready;
                last_beat = transfer && ((rd_ptr + 1'b1) == wr_ptr);
                if (last_beat) begin
                    state_next = FINISHED;
                end
            end

            default: begin
            end
        endcase
    end

    // Collection bookkeeping, checking and drain pointer.
    // Filling the buffer without seeing the last index is flagged through the
    // sticky error only; err_count is reserved for bad entries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            have_first <= 1'b0;
            last_idx   <= 4'd0;
            sum        <= 12'd0;
            err_count  <= 4'd0;
            error      <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_idx   <= index;
                have_first <= 1'b1;
                sum        <= sum + {4'd0, result};
                if (entry_bad) begin
                    error <= 1'b1;
                    if (err_count != 4'hF) begin
                        err_count <= err_count + 4'd1;
                    end
                end
                if (hit_full && !hit_last) begin
                    error <= 1'b1;
                end
            end
            if (transfer) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (capture) begin
            entries[wr_ptr[AW-1:0]] <= {index, result};
        end
    end

endmodule
